// File: rtl/mystery1_pair_sequencer.sv
// Gathers a valid/ready byte stream into (b, c) pairs with a 2-bit select.
// Each pair is held stable on a valid/ready output until downstream accepts it.
module mystery1_pair_sequencer #(
    parameter bit         AUTO_SEL  = 1'b1,
    parameter logic [1:0] SEL_START = 2'd0,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [1:0]       sel_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       sel_out,
    output logic [7:0]       b_out,
    output logic [7:0]       c_out,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0]       SEL_RST = AUTO_SEL ? SEL_START : 2'b00;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             byte_acc;
    logic             pair_acc;

    // in_ready is the one combinational output; it never depends on out_ready,
    // so a byte cannot slip in during the cycle a pair leaves.
    assign in_ready  = (state_q != FULL);
    assign byte_acc  = in_valid && in_ready;
    assign pair_acc  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign sel_out   = sel_q;
    assign b_out     = b_q;
    assign c_out     = c_q;
    assign pair_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (byte_acc) begin
                    b_d = in_data;
                    if (!AUTO_SEL) begin
                        sel_d = sel_in;
                    end
                    state_d = HALF;
                end
            end
            HALF: begin
                // A real byte takes priority over a same-cycle flush.
                if (byte_acc) begin
                    c_d     = in_data;
                    state_d = FULL;
                end else if (flush) begin
                    c_d     = 8'h00;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (pair_acc) begin
                    state_d = EMPTY;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (AUTO_SEL) begin
                        sel_d = sel_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        out_valid_d = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            sel_q       <= SEL_RST;
            b_q         <= 8'h00;
            c_q         <= 8'h00;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            b_q         <= b_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
